// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master drives operands and result-ready; the slave returns the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, through one full-adder cell; result valid WIDTH edges after accept.
// Accepts operands only when idle; holds the result in DONE until out_ready, stalling new operands.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             in_ready_c;
  logic             out_valid_c;

  // a_sr doubles as the result register: minuend bits leave at the LSB
  // while difference bits enter at the MSB.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             nb;
  logic             s;
  logic             c_next;
  logic             last;

  assign nb     = ~b_sr[0];
  assign s      = a_sr[0] ^ nb ^ c_q;
  assign c_next = (a_sr[0] & nb) | (a_sr[0] & c_q) | (nb & c_q);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      c_q    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            c_q  <= ~bus.bin;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sr <= {s, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          c_q  <= c_next;
          cnt  <= cnt + CW'(1);
          // On the final bit a_sr[0]/b_sr[0] are the operand sign bits.
          if (last) begin
            diff_q <= {s, a_sr[WIDTH-1:1]};
            bout_q <= ~c_next;
            ovf_q  <= (a_sr[0] != b_sr[0]) && (s != a_sr[0]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with an expected-result queue.
module tb_serial_subtractor;

  typedef struct packed {
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t last_exp;

  serial_subtractor_if #(.WIDTH(4)) bus ();

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic bin);
    exp_t       r;
    logic [4:0] u;
    int         sv;
    u  = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    sv = int'($signed(a)) - int'($signed(b)) - int'(bin);
    r.diff = u[3:0];
    r.bout = u[4];
    r.ovf  = (sv > 7) || (sv < -8);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pops the expected result, compares it, optionally stalls in DONE, then hands off.
  task automatic collect(input int hold);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: no expected result queued");
      return;
    end
    e = sb.pop_front();
    last_exp = e;
    check("diff", 32'(bus.diff), 32'(e.diff));
    check("bout", 32'(bus.bout), 32'(e.bout));
    check("ovf",  32'(bus.ovf),  32'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a   = 4'hf;
      bus.b   = 4'h0;
      bus.bin = 1'b0;
      tick();
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready",  32'(bus.in_ready),  32'd0);
      check("hold_diff",      32'(bus.diff),      32'(e.diff));
      check("hold_bout_ovf",  32'({bus.bout, bus.ovf}), 32'({e.bout, e.ovf}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("handoff_out_valid", 32'(bus.out_valid), 32'd0);
    check("handoff_in_ready",  32'(bus.in_ready),  32'd1);
    check("diff_kept",         32'(bus.diff),      32'(e.diff));
    if (hold > 0) begin
      tick();
      check("ignored_in_valid", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin, input int hold);
    int n;
    n = 0;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    sb.push_back(model(a, b, bin));
    tick();
    bus.in_valid = 1'b0;
    check("busy_in_ready", 32'(bus.in_ready), 32'd0);
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd4);
    collect(hold);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a   = '0;
    bus.b   = '0;
    bus.bin = 1'b0;
    #2;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff",      32'(bus.diff),      32'd0);
    check("rst_bout_ovf",  32'({bus.bout, bus.ovf}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    run_op(4'd7, 4'd3, 1'b0, 0);
    run_op(4'd3, 4'd7, 1'b0, 0);
    run_op(4'b1000, 4'd1, 1'b0, 0);
    run_op(4'd5, 4'd5, 1'b1, 0);
    run_op(4'd2, 4'd9, 1'b1, 5);
    run_op(4'd0, 4'd15, 1'b1, 0);
    for (int k = 0; k < 4; k++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 0);
    end

    // Abort mid-operation with an asynchronous reset.
    run_op(4'd12, 4'd1, 1'b0, 0);
    bus.a = 4'd7;
    bus.b = 4'd3;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_diff",      32'(bus.diff),      32'd0);
    check("abort_bout_ovf",  32'({bus.bout, bus.ovf}), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    run_op(4'd9, 4'd2, 1'b0, 0);
    check("post_abort_diff", 32'(last_exp.diff), 32'd7);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
